// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch controller owning the program counter.
// Runs from a start address, stalls, branches via a target LUT, halts.
module pc_sequencer #(
   parameter int PC_W   = 8,
   parameter int LUT_AW = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [PC_W-1:0]   start_addr,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [LUT_AW-1:0] target_sel,
   input  logic              halt_req,
   input  logic              lut_we,
   input  logic [LUT_AW-1:0] lut_waddr,
   input  logic [PC_W-1:0]   lut_wdata,
   output logic [PC_W-1:0]   pc,
   output logic              fetch_valid,
   output logic              busy,
   output logic              done
);

   localparam int LUT_N = 2 ** LUT_AW;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [PC_W-1:0] pc_nx;
   logic [PC_W-1:0] lut [LUT_N];
   logic [PC_W-1:0] target;

   // Branch target comes from registered LUT contents (old value on same-cycle write)
   assign target = lut[target_sel];

   // State and PC registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         pc    <= '0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
      end
   end

   // Branch-target table, writable in any state, cleared by reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < LUT_N; i++)
            lut[i] <= '0;
      end else if (lut_we) begin
         lut[lut_waddr] <= lut_wdata;
      end
   end

   // Next state and next PC: halt beats stall beats branch beats increment
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = RUN;
               pc_nx    = start_addr;
            end
         end
         RUN: begin
            if (halt_req)
               state_nx = HALTED;
            else if (stall)
               pc_nx = pc;
            else if (branch_taken)
               pc_nx = target;
            else
               pc_nx = pc + PC_W'(1);
         end
         HALTED: begin
            if (start) begin
               state_nx = RUN;
               pc_nx    = start_addr;
            end
         end
         default: begin
            state_nx = IDLE;
            pc_nx    = '0;
         end
      endcase
   end

   // Status decoded from the registered state; fetch_valid also sees inputs
   assign busy        = (state == RUN);
   assign done        = (state == HALTED);
   assign fetch_valid = busy & ~stall & ~halt_req;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus hand-written
// sequences for async reset and LUT clearing.
module tb_pc_sequencer;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [7:0] start_addr;
   logic       stall;
   logic       branch_taken;
   logic [3:0] target_sel;
   logic       halt_req;
   logic       lut_we;
   logic [3:0] lut_waddr;
   logic [7:0] lut_wdata;
   logic [7:0] pc;
   logic       fetch_valid;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(.PC_W(8), .LUT_AW(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .start_addr   (start_addr),
      .stall        (stall),
      .branch_taken (branch_taken),
      .target_sel   (target_sel),
      .halt_req     (halt_req),
      .lut_we       (lut_we),
      .lut_waddr    (lut_waddr),
      .lut_wdata    (lut_wdata),
      .pc           (pc),
      .fetch_valid  (fetch_valid),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       st;
      logic [7:0] sa;
      logic       sl;
      logic       br;
      logic [3:0] ts;
      logic       hr;
      logic       we;
      logic [3:0] wa;
      logic [7:0] wd;
      logic       efv;
      logic [7:0] epc;
      logic       ebusy;
      logic       edone;
   } vec_t;

   vec_t tab[$];

   function automatic vec_t mk(
      input logic st, input logic [7:0] sa,
      input logic sl, input logic br, input logic [3:0] ts,
      input logic hr, input logic we, input logic [3:0] wa,
      input logic [7:0] wd, input logic efv,
      input logic [7:0] epc, input logic ebusy, input logic edone);
      vec_t v;
      v.st = st; v.sa = sa; v.sl = sl; v.br = br; v.ts = ts;
      v.hr = hr; v.we = we; v.wa = wa; v.wd = wd;
      v.efv = efv; v.epc = epc; v.ebusy = ebusy; v.edone = edone;
      return v;
   endfunction

   task automatic chk(input string name, input int idx,
                      input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h",
                  name, idx, act, exp);
      end
   endtask

   task automatic drive_idle();
      start = 0; start_addr = '0; stall = 0; branch_taken = 0;
      target_sel = '0; halt_req = 0; lut_we = 0;
      lut_waddr = '0; lut_wdata = '0;
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      start = v.st; start_addr = v.sa; stall = v.sl;
      branch_taken = v.br; target_sel = v.ts; halt_req = v.hr;
      lut_we = v.we; lut_waddr = v.wa; lut_wdata = v.wd;
      #1;
      chk("fetch_valid", idx, {7'b0, fetch_valid}, {7'b0, v.efv});
      @(posedge clk);
      #1;
      chk("pc", idx, pc, v.epc);
      chk("busy", idx, {7'b0, busy}, {7'b0, v.ebusy});
      chk("done", idx, {7'b0, done}, {7'b0, v.edone});
   endtask

   initial begin
      //         st sa    sl br ts hr we wa wd    fv pc    bu dn
      // start 0x10, count up
      tab.push_back(mk(1, 8'h10, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h10, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h11, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h12, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h13, 1, 0));
      // halt, then restart at 0x05 while writing lut[3]=0x80
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 8'h13, 0, 1));
      tab.push_back(mk(1, 8'h05, 0, 0, 0, 0, 1, 3, 8'h80, 0, 8'h05, 1, 0));
      // branch via lut[3]
      tab.push_back(mk(0, 8'h00, 0, 1, 3, 0, 0, 0, 8'h00, 1, 8'h80, 1, 0));
      // write lut[5]=0x40 and branch to 5 same cycle: old value 0
      tab.push_back(mk(0, 8'h00, 0, 1, 5, 0, 1, 5, 8'h40, 1, 8'h00, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h01, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 1, 5, 0, 0, 0, 8'h00, 1, 8'h40, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h41, 1, 0));
      // start in RUN ignored
      tab.push_back(mk(1, 8'h77, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h42, 1, 0));
      // reach 0x20 via lut[1]
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 8'h20, 1, 8'h43, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 8'h00, 1, 8'h20, 1, 0));
      // stall 2 cycles, branch in first one is dropped
      tab.push_back(mk(0, 8'h00, 1, 1, 3, 0, 0, 0, 8'h00, 0, 8'h20, 1, 0));
      tab.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h20, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h21, 1, 0));
      // halt with stall -> HALTED
      tab.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00, 0, 8'h21, 0, 1));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h21, 0, 1));
      // wrap from 0xFE
      tab.push_back(mk(1, 8'hFE, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'hFE, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'hFF, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h00, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h01, 1, 0));
      // reach 0x33, halt, hold 5 cycles
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 4, 8'h33, 1, 8'h02, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 1, 4, 0, 0, 0, 8'h00, 1, 8'h33, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 8'h33, 0, 1));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h33, 0, 1));
      tab.push_back(mk(0, 8'h00, 0, 1, 3, 0, 0, 0, 8'h00, 0, 8'h33, 0, 1));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h33, 0, 1));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h33, 0, 1));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h33, 0, 1));
      // restart at 0x00
      tab.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0));
      // lut[2]=0x90, lut[6]=0x47, go to 0x47
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 2, 8'h90, 1, 8'h01, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 6, 8'h47, 1, 8'h02, 1, 0));
      tab.push_back(mk(0, 8'h00, 0, 1, 6, 0, 0, 0, 8'h00, 1, 8'h47, 1, 0));

      drive_idle();
      reset_n = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_pc", 0, pc, 8'h00);
      chk("rst_busy", 0, {7'b0, busy}, 8'h00);
      chk("rst_done", 0, {7'b0, done}, 8'h00);
      chk("rst_fv", 0, {7'b0, fetch_valid}, 8'h00);
      @(negedge clk);
      reset_n = 1;

      for (int i = 0; i < tab.size(); i++)
         apply(tab[i], i + 1);

      // async reset between edges, with an in-flight LUT write
      @(negedge clk);
      drive_idle();
      branch_taken = 1; target_sel = 4'd2;
      lut_we = 1; lut_waddr = 4'd2; lut_wdata = 8'h55;
      #2;
      reset_n = 0;
      #1;
      chk("async_pc", 100, pc, 8'h00);
      chk("async_busy", 100, {7'b0, busy}, 8'h00);
      chk("async_done", 100, {7'b0, done}, 8'h00);
      chk("async_fv", 100, {7'b0, fetch_valid}, 8'h00);
      @(posedge clk);
      #1;
      chk("hold_pc", 101, pc, 8'h00);
      chk("hold_busy", 101, {7'b0, busy}, 8'h00);
      @(negedge clk);
      drive_idle();
      reset_n = 1;

      // LUT must read back zero after reset
      apply(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0), 102);
      apply(mk(0, 8'h00, 0, 1, 2, 0, 0, 0, 8'h00, 1, 8'h00, 1, 0), 103);
      apply(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h01, 1, 0), 104);
      apply(mk(0, 8'h00, 0, 1, 6, 0, 0, 0, 8'h00, 1, 8'h00, 1, 0), 105);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
